hilo_muldiv_unit: RTL

- EX-stage multiply/divide engine that owns the HI/LO register pair.
- Supplies RHLOut to the EX result mux for MFHI/MFLO.
- Executes MULT/MULTU/DIV/DIVU as a multi-cycle operation and handles MTHI/MTLO writes.
- While an operation is in flight it raises busy; the hazard unit uses busy to stall IF/ID/EX.

---
 rtl/hilo_muldiv_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_unit
// Description : EX-stage multiply/divide engine owning the HI/LO pair.
//               Multi-cycle MULT/MULTU (MUL_LAT cycles after start) and a
//               radix-2 restoring DIV/DIVU (32 iterations), plus MTHI/MTLO.
//               busy stalls the front end while an operation is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  input  logic             RHLSel,
  output logic [WIDTH-1:0] RHLOut,
  output logic             busy
);

  localparam logic [2:0] C_OP_MULT  = 3'b001;
  localparam logic [2:0] C_OP_MULTU = 3'b010;
  localparam logic [2:0] C_OP_DIV   = 3'b011;
  localparam logic [2:0] C_OP_DIVU  = 3'b100;
  localparam logic [2:0] C_OP_MTHI  = 3'b101;
  localparam logic [2:0] C_OP_MTLO  = 3'b110;

  // Counter must reach both the divide iteration count and the multiply latency
  localparam int C_CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  // opa: multiplicand, or the dividend/quotient shift register during divide
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 smul_q, smul_d;   // signed multiply
  logic                 sgna_q, sgna_d;   // remainder must be negated
  logic                 negq_q, negq_d;   // quotient must be negated

  logic                 w_accept;
  logic                 w_is_md;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_nx;
  logic [WIDTH-1:0]     w_quo_nx;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  assign w_accept = (state_q == S_IDLE) && start && !flush;
  assign w_is_md  = (op == C_OP_MULT) || (op == C_OP_MULTU) ||
                    (op == C_OP_DIV)  || (op == C_OP_DIVU);

  // Sign-extending for MULT makes the truncated 2W-bit product the signed one
  assign w_prod = {{WIDTH{smul_q & opa_q[WIDTH-1]}}, opa_q} *
                  {{WIDTH{smul_q & opb_q[WIDTH-1]}}, opb_q};

  // One restoring step: shift next dividend bit in, subtract if it fits.
  // The partial remainder stays below the divisor, so the difference fits W bits.
  assign w_rem_sh  = {rem_q, opa_q[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, opb_q});
  assign w_rem_nx  = w_ge ? (w_rem_sh[WIDTH-1:0] - opb_q) : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx  = {opa_q[WIDTH-2:0], w_ge};
  assign w_quo_fix = negq_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = sgna_q ? -w_rem_nx : w_rem_nx;

  assign RHLOut = RHLSel ? hi_q : lo_q;
  assign busy   = (state_q != S_IDLE) | (w_accept & w_is_md);

  // Next-state, operand capture, divider iteration and HI/LO write-back
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    smul_d  = smul_q;
    sgna_d  = sgna_q;
    negq_d  = negq_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              C_OP_MULT, C_OP_MULTU: begin
                opa_d   = A;
                opb_d   = B;
                smul_d  = (op == C_OP_MULT);
                state_d = S_MUL;
                cnt_d   = C_CNT_W'(1);
              end
              C_OP_DIV, C_OP_DIVU: begin
                sgna_d  = (op == C_OP_DIV) & A[WIDTH-1];
                negq_d  = (op == C_OP_DIV) & (A[WIDTH-1] ^ B[WIDTH-1]);
                opa_d   = ((op == C_OP_DIV) & A[WIDTH-1]) ? -A : A;
                opb_d   = ((op == C_OP_DIV) & B[WIDTH-1]) ? -B : B;
                rem_d   = '0;
                state_d = S_DIV;
                cnt_d   = C_CNT_W'(1);
              end
              C_OP_MTHI: hi_d = A;
              C_OP_MTLO: lo_d = A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == C_CNT_W'(MUL_LAT)) begin
            hi_d    = w_prod[2*WIDTH-1:WIDTH];
            lo_d    = w_prod[WIDTH-1:0];
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + C_CNT_W'(1);
          end
        end
        S_DIV: begin
          opa_d = w_quo_nx;
          rem_d = w_rem_nx;
          if (cnt_q == C_CNT_W'(WIDTH)) begin
            // Zero divisor: the datapath already yields |A| as remainder,
            // whose sign fix restores A; only the quotient needs forcing.
            lo_d    = (opb_q == '0) ? '1 : w_quo_fix;
            hi_d    = w_rem_fix;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + C_CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      smul_q  <= 1'b0;
      sgna_q  <= 1'b0;
      negq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      smul_q  <= smul_d;
      sgna_q  <= sgna_d;
      negq_q  <= negq_d;
    end
  end

endmodule
`default_nettype wire
